iso_activation_sequencer: RTL and testbench

Sequences ISO 7816-3 card activation, warm reset and deactivation for the master interface. It drives the card supply, reset, clock-enable and I/O-force-low controls in the mandated order. It times the RST-low window and the ATR window, and captures the TS character from the UART receiver. If the card stays silent after a cold reset, it performs one automatic warm reset, then deactivates. The block sits between the host command register and the card-side pad drivers and runs on the card clock domain.

---
 rtl/iso_activation_sequencer_if.sv | 32 +++
 rtl/iso_activation_sequencer.sv | 196 +++++++++++++++++++
 tb/tb_iso_activation_sequencer.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/iso_activation_sequencer_if.sv
// Host command / receiver / card-pad bundle for the ISO 7816-3 activation sequencer.
// The master side issues commands and receives status; the slave side is the sequencer.
interface iso_activation_sequencer_if;
    logic       coldStart;
    logic       warmStart;
    logic       deactivate;
    logic       endOfRx;
    logic [7:0] rxData;
    logic       isoVdd;
    logic       isoReset;
    logic       isoClkEn;
    logic       sioForceLow;
    logic       busy;
    logic       isActive;
    logic       tsReceived;
    logic       useIndirectConvention;
    logic       tsError;
    logic       atrIsEarly;
    logic       atrTimeout;

    modport master (
        output coldStart, warmStart, deactivate, endOfRx, rxData,
        input  isoVdd, isoReset, isoClkEn, sioForceLow, busy, isActive,
               tsReceived, useIndirectConvention, tsError, atrIsEarly, atrTimeout
    );

    modport slave (
        input  coldStart, warmStart, deactivate, endOfRx, rxData,
        output isoVdd, isoReset, isoClkEn, sioForceLow, busy, isActive,
               tsReceived, useIndirectConvention, tsError, atrIsEarly, atrTimeout
    );
endinterface

// File: rtl/iso_activation_sequencer.sv
// ISO 7816-3 cold/warm activation and deactivation sequencer with TS capture,
// one automatic warm retry on a silent card, and registered pad controls.
//
// state      | meaning
// stOff      | card unpowered, I/O forced low
// stVddUp    | supply on, waiting for it to settle
// stRstLow   | clock running, RST held low
// stWaitAtr  | RST released, waiting for TS
// stActive   | TS received, card in session
// stWarmRst  | warm reset: RST low, supply and clock held
// stDeactRst | deactivation step 1: RST low
// stDeactClk | deactivation step 2: clock stopped
// stDeactIo  | deactivation step 3: I/O forced low
// stDeactVdd | deactivation step 4: supply off
module iso_activation_sequencer #(
    parameter int unsigned VDD_SETTLE     = 64,
    parameter int unsigned RST_LOW_CYCLES = 400,
    parameter int unsigned ATR_EARLY      = 400,
    parameter int unsigned ATR_TIMEOUT    = 40000,
    parameter int unsigned DEACT_STEP     = 8
) (
    input  logic                          isoClk,
    input  logic                          nReset,
    iso_activation_sequencer_if.slave     bus
);

    typedef enum logic [3:0] {
        stOff, stVddUp, stRstLow, stWaitAtr, stActive,
        stWarmRst, stDeactRst, stDeactClk, stDeactIo, stDeactVdd
    } stateT;

    localparam logic [15:0] VDD_LAST   = 16'(VDD_SETTLE - 1);
    localparam logic [15:0] RST_LAST   = 16'(RST_LOW_CYCLES - 1);
    localparam logic [15:0] EARLY_LIM  = 16'(ATR_EARLY);
    localparam logic [15:0] ATR_LAST   = 16'(ATR_TIMEOUT - 1);
    localparam logic [15:0] STEP_LAST  = 16'(DEACT_STEP - 1);

    stateT       state, nextState;
    logic [15:0] cycleCnt;
    logic        retryFlag;

    logic        inDeact;
    logic        deactGo, warmGo, coldGo, rxGo, atrExpired;

    logic        vddNext, resetNext, clkEnNext, forceLowNext, busyNext, activeNext;
    logic        vddQ, resetQ, clkEnQ, forceLowQ, busyQ, activeQ;
    logic        tsReceivedQ, indirectQ, tsErrorQ, earlyQ, timeoutQ;

    // Command qualification encodes the pulse priority: deactivate > warmStart > endOfRx > timeout.
    always_comb begin
        inDeact    = (state == stDeactRst) || (state == stDeactClk) ||
                     (state == stDeactIo)  || (state == stDeactVdd);
        deactGo    = bus.deactivate && (state != stOff) && !inDeact;
        warmGo     = bus.warmStart && !deactGo &&
                     ((state == stActive) || (state == stWaitAtr));
        coldGo     = bus.coldStart && (state == stOff);
        rxGo       = bus.endOfRx && (state == stWaitAtr) && !deactGo && !warmGo;
        atrExpired = (state == stWaitAtr) && (cycleCnt == ATR_LAST) &&
                     !deactGo && !warmGo && !bus.endOfRx;
    end

    always_ff @(posedge isoClk or negedge nReset) begin
        if (!nReset) begin
            state    <= stOff;
            cycleCnt <= '0;
        end else begin
            state <= nextState;
            if (nextState != state)
                cycleCnt <= '0;
            else if (cycleCnt != 16'hFFFF)
                cycleCnt <= cycleCnt + 16'd1;
        end
    end

    always_comb begin
        nextState = state;
        if (deactGo) begin
            nextState = stDeactRst;
        end else if (warmGo) begin
            nextState = stWarmRst;
        end else begin
            case (state)
                stOff:      if (coldGo) nextState = stVddUp;
                stVddUp:    if (cycleCnt == VDD_LAST) nextState = stRstLow;
                stRstLow:   if (cycleCnt == RST_LAST) nextState = stWaitAtr;
                stWaitAtr: begin
                    if (rxGo)
                        nextState = stActive;
                    else if (atrExpired)
                        nextState = retryFlag ? stDeactRst : stWarmRst;
                end
                stActive:   nextState = stActive;
                stWarmRst:  if (cycleCnt == RST_LAST) nextState = stWaitAtr;
                stDeactRst: if (cycleCnt == STEP_LAST) nextState = stDeactClk;
                stDeactClk: if (cycleCnt == STEP_LAST) nextState = stDeactIo;
                stDeactIo:  if (cycleCnt == STEP_LAST) nextState = stDeactVdd;
                stDeactVdd: if (cycleCnt == STEP_LAST) nextState = stOff;
                default:    nextState = stOff;
            endcase
        end
    end

    // Decoded from nextState so each registered pad changes on the edge entering the state.
    always_comb begin
        vddNext      = 1'b0;
        resetNext    = 1'b0;
        clkEnNext    = 1'b0;
        forceLowNext = 1'b0;
        busyNext     = 1'b1;
        activeNext   = 1'b0;
        case (nextState)
            stOff:      begin forceLowNext = 1'b1; busyNext = 1'b0; end
            stVddUp:    vddNext = 1'b1;
            stRstLow:   begin vddNext = 1'b1; clkEnNext = 1'b1; end
            stWaitAtr:  begin vddNext = 1'b1; clkEnNext = 1'b1; resetNext = 1'b1; end
            stActive: begin
                vddNext    = 1'b1;
                clkEnNext  = 1'b1;
                resetNext  = 1'b1;
                busyNext   = 1'b0;
                activeNext = 1'b1;
            end
            stWarmRst:  begin vddNext = 1'b1; clkEnNext = 1'b1; end
            stDeactRst: begin vddNext = 1'b1; clkEnNext = 1'b1; end
            stDeactClk: vddNext = 1'b1;
            stDeactIo:  begin vddNext = 1'b1; forceLowNext = 1'b1; end
            stDeactVdd: forceLowNext = 1'b1;
            default:    begin forceLowNext = 1'b1; busyNext = 1'b0; end
        endcase
    end

    always_ff @(posedge isoClk or negedge nReset) begin
        if (!nReset) begin
            vddQ      <= 1'b0;
            resetQ    <= 1'b0;
            clkEnQ    <= 1'b0;
            forceLowQ <= 1'b1;
            busyQ     <= 1'b0;
            activeQ   <= 1'b0;
        end else begin
            vddQ      <= vddNext;
            resetQ    <= resetNext;
            clkEnQ    <= clkEnNext;
            forceLowQ <= forceLowNext;
            busyQ     <= busyNext;
            activeQ   <= activeNext;
        end
    end

    // TS decode is registered at capture time; only the decoded flags are observable.
    always_ff @(posedge isoClk or negedge nReset) begin
        if (!nReset) begin
            tsReceivedQ <= 1'b0;
            indirectQ   <= 1'b0;
            tsErrorQ    <= 1'b0;
            earlyQ      <= 1'b0;
            timeoutQ    <= 1'b0;
            retryFlag   <= 1'b0;
        end else if (coldGo) begin
            tsReceivedQ <= 1'b0;
            indirectQ   <= 1'b0;
            tsErrorQ    <= 1'b0;
            earlyQ      <= 1'b0;
            timeoutQ    <= 1'b0;
            retryFlag   <= 1'b0;
        end else if (warmGo) begin
            tsReceivedQ <= 1'b0;
            indirectQ   <= 1'b0;
            tsErrorQ    <= 1'b0;
            earlyQ      <= 1'b0;
        end else if (rxGo) begin
            tsReceivedQ <= 1'b1;
            indirectQ   <= (bus.rxData == 8'hFC);
            tsErrorQ    <= (bus.rxData != 8'h3B) && (bus.rxData != 8'hFC);
            earlyQ      <= (cycleCnt < EARLY_LIM);
        end else if (atrExpired) begin
            if (retryFlag)
                timeoutQ <= 1'b1;
            else
                retryFlag <= 1'b1;
        end
    end

    assign bus.isoVdd                = vddQ;
    assign bus.isoReset              = resetQ;
    assign bus.isoClkEn              = clkEnQ;
    assign bus.sioForceLow           = forceLowQ;
    assign bus.busy                  = busyQ;
    assign bus.isActive              = activeQ;
    assign bus.tsReceived            = tsReceivedQ;
    assign bus.useIndirectConvention = indirectQ;
    assign bus.tsError               = tsErrorQ;
    assign bus.atrIsEarly            = earlyQ;
    assign bus.atrTimeout            = timeoutQ;

endmodule

// File: tb/tb_iso_activation_sequencer.sv
// Directed bench for iso_activation_sequencer: cold/warm activation, TS decode,
// silent-card retry and timeout, deactivation ordering, and async reset.
module tb_iso_activation_sequencer;

    logic isoClk;
    logic nReset;
    int   testsRun;
    int   failCount;

    iso_activation_sequencer_if busIf ();

    iso_activation_sequencer dut (
        .isoClk (isoClk),
        .nReset (nReset),
        .bus    (busIf)
    );

    initial isoClk = 1'b0;
    always #5 isoClk = ~isoClk;

    task automatic tick(input int n);
        repeat (n) @(posedge isoClk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        testsRun++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic pulseCold();
        busIf.coldStart = 1'b1; tick(1); busIf.coldStart = 1'b0;
    endtask

    task automatic pulseWarm();
        busIf.warmStart = 1'b1; tick(1); busIf.warmStart = 1'b0;
    endtask

    task automatic pulseDeact();
        busIf.deactivate = 1'b1; tick(1); busIf.deactivate = 1'b0;
    endtask

    task automatic pulseRx(input logic [7:0] data);
        busIf.rxData = data; busIf.endOfRx = 1'b1; tick(1); busIf.endOfRx = 1'b0;
    endtask

    // Cold start from OFF; returns just after the edge that enters WAIT_ATR.
    task automatic coldTiming(input string tag);
        pulseCold();
        check({tag, "_vddUp"},     busIf.isoVdd,   1'b1);
        check({tag, "_clkEnOff"},  busIf.isoClkEn, 1'b0);
        check({tag, "_sioRel"},    busIf.sioForceLow, 1'b0);
        tick(63);
        check({tag, "_clkEnLate"}, busIf.isoClkEn, 1'b0);
        tick(1);
        check({tag, "_clkEnOn"},   busIf.isoClkEn, 1'b1);
        check({tag, "_rstLow"},    busIf.isoReset, 1'b0);
        tick(399);
        check({tag, "_rstLate"},   busIf.isoReset, 1'b0);
        tick(1);
        check({tag, "_rstRel"},    busIf.isoReset, 1'b1);
        check({tag, "_busyAtr"},   busIf.busy,     1'b1);
    endtask

    // Starts just after the edge that entered DEACT_RST.
    task automatic deactOrder(input string tag);
        check({tag, "_rstDrop"},  busIf.isoReset, 1'b0);
        tick(7);
        check({tag, "_clkHold"},  busIf.isoClkEn, 1'b1);
        tick(1);
        check({tag, "_clkDrop"},  busIf.isoClkEn, 1'b0);
        check({tag, "_sioHold"},  busIf.sioForceLow, 1'b0);
        tick(7);
        check({tag, "_sioLate"},  busIf.sioForceLow, 1'b0);
        tick(1);
        check({tag, "_sioForce"}, busIf.sioForceLow, 1'b1);
        check({tag, "_vddHold"},  busIf.isoVdd, 1'b1);
        tick(7);
        check({tag, "_vddLate"},  busIf.isoVdd, 1'b1);
        tick(1);
        check({tag, "_vddDrop"},  busIf.isoVdd, 1'b0);
        check({tag, "_busyVdd"},  busIf.busy, 1'b1);
        tick(7);
        check({tag, "_busyLate"}, busIf.busy, 1'b1);
        tick(1);
        check({tag, "_offBusy"},  busIf.busy, 1'b0);
        check({tag, "_offSio"},   busIf.sioForceLow, 1'b1);
    endtask

    initial begin
        testsRun  = 0;
        failCount = 0;
        nReset    = 1'b0;
        busIf.coldStart  = 1'b0;
        busIf.warmStart  = 1'b0;
        busIf.deactivate = 1'b0;
        busIf.endOfRx    = 1'b0;
        busIf.rxData     = 8'h00;
        tick(3);
        check("rst_vdd",   busIf.isoVdd,      1'b0);
        check("rst_sio",   busIf.sioForceLow, 1'b1);
        check("rst_reset", busIf.isoReset,    1'b0);
        check("rst_busy",  busIf.busy,        1'b0);
        check("rst_tsRx",  busIf.tsReceived,  1'b0);
        nReset = 1'b1;
        tick(2);

        // Cold start, TS 3B well after the early window
        coldTiming("cold1");
        tick(1000);
        pulseRx(8'h3B);
        check("ts3B_active",   busIf.isActive,              1'b1);
        check("ts3B_tsRx",     busIf.tsReceived,            1'b1);
        check("ts3B_err",      busIf.tsError,               1'b0);
        check("ts3B_indirect", busIf.useIndirectConvention, 1'b0);
        check("ts3B_early",    busIf.atrIsEarly,            1'b0);
        check("ts3B_busy",     busIf.busy,                  1'b0);
        pulseCold();
        check("coldInActive", busIf.isActive, 1'b1);

        // Warm reset from ACTIVE, then an invalid TS
        pulseWarm();
        check("warm_rstLow", busIf.isoReset,   1'b0);
        check("warm_vdd",    busIf.isoVdd,     1'b1);
        check("warm_clkEn",  busIf.isoClkEn,   1'b1);
        check("warm_tsClr",  busIf.tsReceived, 1'b0);
        tick(399);
        check("warm_rstLate", busIf.isoReset, 1'b0);
        tick(1);
        check("warm_rstRel",  busIf.isoReset, 1'b1);
        pulseRx(8'h55);
        check("ts55_err",      busIf.tsError,               1'b1);
        check("ts55_tsRx",     busIf.tsReceived,            1'b1);
        check("ts55_indirect", busIf.useIndirectConvention, 1'b0);
        pulseDeact();
        deactOrder("deact1");
        check("deact1_flagHold", busIf.tsError, 1'b1);

        // Inverse-convention TS inside the early window
        pulseCold();
        check("cold2_tsClr", busIf.tsError, 1'b0);
        tick(464);
        tick(200);
        pulseRx(8'hFC);
        check("tsFC_indirect", busIf.useIndirectConvention, 1'b1);
        check("tsFC_early",    busIf.atrIsEarly,            1'b1);
        check("tsFC_err",      busIf.tsError,               1'b0);
        check("tsFC_active",   busIf.isActive,              1'b1);
        pulseDeact();
        tick(32);
        check("deact2_off", busIf.busy, 1'b0);

        // deactivate and endOfRx together in WAIT_ATR
        pulseCold();
        tick(464);
        tick(50);
        busIf.rxData = 8'h3B;
        busIf.endOfRx = 1'b1;
        busIf.deactivate = 1'b1;
        tick(1);
        busIf.endOfRx = 1'b0;
        busIf.deactivate = 1'b0;
        check("coinc_tsRx",   busIf.tsReceived, 1'b0);
        check("coinc_active", busIf.isActive,   1'b0);
        check("coinc_clkEn",  busIf.isoClkEn,   1'b1);
        deactOrder("coinc");

        // Silent card: warm retry, then timeout and deactivation
        pulseCold();
        tick(464);
        tick(39999);
        check("silent_rstHold", busIf.isoReset, 1'b1);
        tick(1);
        check("silent_retry",   busIf.isoReset,   1'b0);
        check("silent_noTo",    busIf.atrTimeout, 1'b0);
        check("silent_vdd",     busIf.isoVdd,     1'b1);
        tick(400);
        check("silent_rstRel2", busIf.isoReset, 1'b1);
        tick(39999);
        check("silent_toLate",  busIf.atrTimeout, 1'b0);
        tick(1);
        check("silent_timeout", busIf.atrTimeout, 1'b1);
        deactOrder("silentDeact");
        check("silent_toSticky", busIf.atrTimeout, 1'b1);

        // Async reset in the middle of RST_LOW
        pulseCold();
        tick(164);
        check("mid_clkEn", busIf.isoClkEn, 1'b1);
        nReset = 1'b0;
        #2;
        check("async_vdd",   busIf.isoVdd,      1'b0);
        check("async_clkEn", busIf.isoClkEn,    1'b0);
        check("async_sio",   busIf.sioForceLow, 1'b1);
        check("async_busy",  busIf.busy,        1'b0);
        #10;
        nReset = 1'b1;
        tick(2);
        check("post_rst_vdd", busIf.isoVdd, 1'b0);
        coldTiming("cold2");

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
